gpmc_target: RTL and testbench
==============================

Name: gpmc_target

Overview:
- Synchronous GPMC responder for the ARM host's multiplexed 16-bit address/data bus in chip-select 1 space.
- Decodes address and data phases, turns host writes into single-cycle register-bus write strobes, and services single-beat reads from the register bus.
- Sits between the GPMC pads (split tri-state: in/out/oe) and the fabric register file.
- Clocked directly by gpmc_clk; the host stops the clock between transactions.

Parameters:
- RD_LATENCY, 2, cycles from reg_rd_en high to reg_rd_data valid (1..7).
- ADDR_W, 16, width of reg_addr; the latched AD value is truncated to this width.

Ports:
- gpmc_clk  in  1  GPMC clock, rising-edge sampling.
- reset_n  in  1  asynchronous, active-low reset.
- gpmc_ad_in  in  16  AD bus as seen at the pad.
- gpmc_ad_out  out  16  read data driven toward the pad.
- gpmc_ad_oe  out  1  pad output enable, 1 = drive.
- gpmc_advn  in  1  address valid, active low.
- gpmc_csn1  in  1  chip select, active low.
- gpmc_wein  in  1  write enable, active low; sampled in the address phase.
- gpmc_oen  in  1  output enable, active low.
- reg_addr  out  ADDR_W  register word address.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  16  write data.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  16  read return, valid RD_LATENCY cycles after reg_rd_en.

Behaviour:
- Reset (async assert, sync release): state=IDLE; reg_addr=0; reg_wr_data=0; reg_wr_en=0; reg_rd_en=0; gpmc_ad_out=0; gpmc_ad_oe=0.
- Address phase: a rising edge with csn1=0 and advn=0, in any state. Latches addr=gpmc_ad_in[ADDR_W-1:0] and dir=wein. Next state: WR if wein=0, RD_ISSUE if wein=1.
- WR: each rising edge with csn1=0 and advn=1 is one data beat.
  - Registered outputs for the beat: reg_wr_data=gpmc_ad_in, reg_addr=current addr, reg_wr_en=1 for exactly one cycle.
  - After the beat, addr increments by 1 (burst), wrapping modulo 2^ADDR_W.
  - The first data beat is the edge immediately after the address edge. Write latency from data edge to strobe is 1 cycle.
- RD_ISSUE: for one cycle, reg_rd_en=1 and reg_addr=addr, then go to RD_WAIT. A down-counter is loaded with RD_LATENCY.
- RD_WAIT: on the edge where the counter expires, capture reg_rd_data into gpmc_ad_out, then go to RD_DATA.
- RD_DATA:
  - gpmc_ad_oe = 1 only while state=RD_DATA, csn1=0 and oen=0. The decode is registered: oe rises one edge after oen is sampled low.
  - gpmc_ad_out holds its value until the next read capture.
  - Single beat only; no read bursts.
- gpmc_ad_oe is never 1 in IDLE, WR, RD_ISSUE or RD_WAIT.
- Any rising edge with csn1=1 returns the block to IDLE and drops gpmc_ad_oe on that edge.
  - A pending read return is discarded: gpmc_ad_out is not updated and no error is raised.
  - A reg_rd_en already issued is not retracted.
- advn=0 during WR or RD_* restarts with a new address phase. Any in-flight read return is discarded.
- wein is ignored outside the address phase. oen is ignored in WR.
- Strobe exclusivity: reg_wr_en and reg_rd_en are never both 1 in the same cycle.

Optional Feature:
- Macro: GPMC_TARGET_WAIT_EN.
- Defined: adds output gpmc_wait (1 bit, reset 1 = ready, active-low wait).
  - gpmc_wait is driven 0 from the edge after a read address phase until the edge that captures read data, then back to 1.
  - Forced to 1 in IDLE and WR.
  - The host may run with wait-monitoring enabled instead of fixed wait states.
- Undefined: port absent. The host must be configured with at least RD_LATENCY+2 read wait cycles.

Test Plan:
- Reset mid-read: assert reset_n=0 during RD_WAIT -> outputs return immediately to reset values; a following write to 0x0020 works normally.
- Single write: addr 0x1000, wein=0, data 0xABCD, then csn1=1 -> one reg_wr_en pulse with reg_addr=0x1000, reg_wr_data=0xABCD; gpmc_ad_oe stays 0 throughout.
- Burst write at 0xFFFE, data 0x1111, 0x2222, 0x3333 -> three strobes at addresses 0xFFFE, 0xFFFF, 0x0000 (wrap), with matching data.
- Read with RD_LATENCY=2: addr 0x0042, wein=1, model returns 0x5A5A -> reg_rd_en one cycle after the address edge; gpmc_ad_out=0x5A5A captured 2 cycles later; gpmc_ad_oe=1 only while oen=0 and csn1=0.
- Aborted read: csn1 deasserted during RD_WAIT -> gpmc_ad_oe never asserts; gpmc_ad_out keeps its prior value; state returns to IDLE.
- Back-to-back: write 0x1000/0xABCD four times with a clock stop between each -> exactly four strobes with identical address and data, and no spurious reg_rd_en.

Source files
------------

// File: rtl/gpmc_target.sv
// GPMC CS1 responder: muxed 16-bit AD bus to single-cycle register strobes.
// Optional macro GPMC_TARGET_WAIT_EN adds the active-low gpmc_wait output.
module gpmc_target #(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 16
) (
  input  logic              gpmc_clk,
  input  logic              reset_n,
  input  logic [15:0]       gpmc_ad_in,
  output logic [15:0]       gpmc_ad_out,
  output logic              gpmc_ad_oe,
`ifdef GPMC_TARGET_WAIT_EN
  output logic              gpmc_wait,
`endif
  input  logic              gpmc_advn,
  input  logic              gpmc_csn1,
  input  logic              gpmc_wein,
  input  logic              gpmc_oen,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [15:0]       reg_wr_data,
  output logic              reg_rd_en,
  input  logic [15:0]       reg_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_DATA
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [15:0]       wr_data_q;
  logic [15:0]       ad_out_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic              oe_q;
  logic [2:0]        cnt_q;

  assign addr_d = addr_q + ADDR_W'(1);

  always_ff @(posedge gpmc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      ad_out_q   <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      oe_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      if (gpmc_csn1) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
      end else if (!gpmc_advn) begin
        addr_q  <= gpmc_ad_in[ADDR_W-1:0];
        state_q <= gpmc_wein ? RD_ISSUE : WR;
        oe_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            oe_q <= 1'b0;
          end
          WR: begin
            wr_data_q  <= gpmc_ad_in;
            reg_addr_q <= addr_q;
            wr_en_q    <= 1'b1;
            addr_q     <= addr_d;
            oe_q       <= 1'b0;
          end
          RD_ISSUE: begin
            rd_en_q    <= 1'b1;
            reg_addr_q <= addr_q;
            cnt_q      <= 3'(RD_LATENCY);
            state_q    <= RD_WAIT;
            oe_q       <= 1'b0;
          end
          RD_WAIT: begin
            oe_q <= 1'b0;
            if (cnt_q == 3'd1) begin
              ad_out_q <= reg_rd_data;
              state_q  <= RD_DATA;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
          RD_DATA: begin
            oe_q <= !gpmc_oen;
          end
          default: begin
            state_q <= IDLE;
            oe_q    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef GPMC_TARGET_WAIT_EN
  logic wait_q;

  // Low from read issue until the capture edge; high otherwise.
  always_ff @(posedge gpmc_clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= 1'b1;
    end else if (gpmc_csn1 || !gpmc_advn) begin
      wait_q <= 1'b1;
    end else if (state_q == RD_ISSUE) begin
      wait_q <= 1'b0;
    end else if (state_q == RD_WAIT && cnt_q == 3'd1) begin
      wait_q <= 1'b1;
    end
  end

  assign gpmc_wait = wait_q;
`endif

  assign gpmc_ad_out = ad_out_q;
  assign gpmc_ad_oe  = oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_en   = rd_en_q;

endmodule

// File: tb/tb_gpmc_target.sv
// Scoreboard bench for gpmc_target: random host transactions vs a
// register-file reference model and expected strobe queues.
module tb_gpmc_target;
  localparam int L = 2;

  logic        gpmc_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] ad       = '0;
  logic        advn     = 1'b1;
  logic        csn1     = 1'b1;
  logic        wein     = 1'b1;
  logic        oen      = 1'b1;
  logic [15:0] reg_rd_data = '0;
  logic [15:0] gpmc_ad_out;
  logic        gpmc_ad_oe;
  logic [15:0] reg_addr;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        reg_rd_en;
`ifdef GPMC_TARGET_WAIT_EN
  logic        gpmc_wait;
`endif

  gpmc_target #(.RD_LATENCY(L), .ADDR_W(16)) dut (
    .gpmc_clk   (gpmc_clk),
    .reset_n    (reset_n),
    .gpmc_ad_in (ad),
    .gpmc_ad_out(gpmc_ad_out),
    .gpmc_ad_oe (gpmc_ad_oe),
`ifdef GPMC_TARGET_WAIT_EN
    .gpmc_wait  (gpmc_wait),
`endif
    .gpmc_advn  (advn),
    .gpmc_csn1  (csn1),
    .gpmc_wein  (wein),
    .gpmc_oen   (oen),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_data(reg_wr_data),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         wrq[$];
  logic [15:0] rdaq[$];
  logic [15:0] rddq[$];
  int          total = 0;
  int          bad   = 0;
  logic        oe_allowed = 1'b0;
  logic [15:0] last_out   = '0;
  bit          clk_run    = 1'b1;

  initial forever begin
    #5;
    if (clk_run) gpmc_clk = ~gpmc_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  function automatic logic [15:0] regval(input logic [15:0] a);
    if (a == 16'h0042) return 16'h5A5A;
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Register file: garbage until RD_LATENCY cycles after the strobe.
  bit          pend = 0;
  int          k    = 0;
  logic [15:0] paddr;
  always @(negedge gpmc_clk) begin
    if (reg_rd_en) begin
      pend = 1;
      k = 0;
      paddr = reg_addr;
      reg_rd_data = 16'($urandom);
    end
    if (pend) begin
      if (k == L - 1) begin
        reg_rd_data = regval(paddr);
        pend = 0;
      end else begin
        k++;
      end
    end
  end

  logic oe_prev = 1'b0;
  always @(posedge gpmc_clk) begin
    #1;
    if (!reset_n) begin
      oe_prev = 1'b0;
    end else begin
      chk("strobe_excl", 32'(reg_wr_en & reg_rd_en), 0);
      if (reg_wr_en) begin
        if (wrq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected actual=%h/%h required=no strobe",
                   reg_addr, reg_wr_data);
        end else begin
          wr_t e;
          e = wrq.pop_front();
          chk("wr_addr", 32'(reg_addr), 32'(e.a));
          chk("wr_data", 32'(reg_wr_data), 32'(e.d));
        end
      end
      if (reg_rd_en) begin
        if (rdaq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected actual=%h required=no strobe",
                   reg_addr);
        end else begin
          chk("rd_addr", 32'(reg_addr), 32'(rdaq.pop_front()));
        end
      end
      if (!oe_allowed) chk("oe_window", 32'(gpmc_ad_oe), 0);
      if (gpmc_ad_oe && !oe_prev) begin
        if (rddq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL oe_unexpected actual=%h required=no drive",
                   gpmc_ad_out);
        end else begin
          chk("rd_drive", 32'(gpmc_ad_out), 32'(rddq.pop_front()));
        end
      end
      oe_prev = gpmc_ad_oe;
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d[4],
                    input int n);
    @(negedge gpmc_clk);
    csn1 = 0; advn = 0; wein = 0; ad = a; oen = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge gpmc_clk);
      advn = 1; wein = 1'($urandom); oen = 1'($urandom); ad = d[i];
      wrq.push_back(wr_t'{a: a + 16'(i), d: d[i]});
    end
    @(negedge gpmc_clk);
    csn1 = 1; oen = 1; wein = 1;
    @(negedge gpmc_clk);
  endtask

  // mode 0: full read, 1: csn abort in wait, 2: leave for a restart
  task automatic rd(input logic [15:0] a, input int mode);
    logic [15:0] e;
    e = regval(a);
    @(negedge gpmc_clk);
    csn1 = 0; advn = 0; wein = 1; ad = a; oen = 1;
    @(posedge gpmc_clk); #1;
    chk("rd_en_addr_edge", 32'(reg_rd_en), 0);
    @(negedge gpmc_clk);
    advn = 1; wein = 1'($urandom); ad = 16'($urandom);
    rdaq.push_back(a);
    @(posedge gpmc_clk); #1;
    chk("rd_en_issue", 32'(reg_rd_en), 1);
`ifdef GPMC_TARGET_WAIT_EN
    chk("wait_low", 32'(gpmc_wait), 0);
`endif
    if (mode == 2) return;
    if (mode == 1) begin
      @(negedge gpmc_clk);
      csn1 = 1; oen = 1'($urandom);
      repeat (L + 2) @(posedge gpmc_clk);
      #1;
      chk("abort_out", 32'(gpmc_ad_out), 32'(last_out));
      chk("abort_oe", 32'(gpmc_ad_oe), 0);
      @(negedge gpmc_clk);
      oen = 1;
      return;
    end
    @(negedge gpmc_clk);
    oen = 1'($urandom);
    repeat (L) @(posedge gpmc_clk);
    #1;
    chk("rd_capture", 32'(gpmc_ad_out), 32'(e));
    chk("oe_pre", 32'(gpmc_ad_oe), 0);
`ifdef GPMC_TARGET_WAIT_EN
    chk("wait_high", 32'(gpmc_wait), 1);
`endif
    last_out = e;
    rddq.push_back(e);
    @(negedge gpmc_clk);
    oen = 0; oe_allowed = 1;
    @(posedge gpmc_clk); #1;
    chk("oe_on", 32'(gpmc_ad_oe), 1);
    repeat ($urandom_range(0, 2)) @(posedge gpmc_clk);
    @(negedge gpmc_clk);
    csn1 = 1; oen = 1;
    @(posedge gpmc_clk); #1;
    chk("oe_off", 32'(gpmc_ad_oe), 0);
    chk("out_hold", 32'(gpmc_ad_out), 32'(e));
    @(negedge gpmc_clk);
    oe_allowed = 0;
  endtask

  task automatic clk_stop();
    @(negedge gpmc_clk);
    clk_run = 0;
    #47;
    clk_run = 1;
  endtask

  logic [15:0] dd[4];

  initial begin
    repeat (3) @(posedge gpmc_clk);
    #1;
    chk("rst_ad_out", 32'(gpmc_ad_out), 0);
    chk("rst_oe", 32'(gpmc_ad_oe), 0);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wr_data", 32'(reg_wr_data), 0);
    chk("rst_wr_en", 32'(reg_wr_en), 0);
    chk("rst_rd_en", 32'(reg_rd_en), 0);
    @(negedge gpmc_clk);
    reset_n = 1;

    // reset asserted while waiting for read data
    @(negedge gpmc_clk);
    csn1 = 0; advn = 0; wein = 1; ad = 16'h0042;
    @(negedge gpmc_clk);
    advn = 1;
    rdaq.push_back(16'h0042);
    @(posedge gpmc_clk); #1;
    chk("mid_rd_issue", 32'(reg_rd_en), 1);
    @(posedge gpmc_clk); #2;
    reset_n = 0;
    #1;
    chk("mid_rst_addr", 32'(reg_addr), 0);
    chk("mid_rst_out", 32'(gpmc_ad_out), 0);
    chk("mid_rst_oe", 32'(gpmc_ad_oe), 0);
    chk("mid_rst_rd_en", 32'(reg_rd_en), 0);
    last_out = 0;
    @(negedge gpmc_clk);
    csn1 = 1;
    @(negedge gpmc_clk);
    reset_n = 1;
    dd[0] = 16'h0F0F;
    wr(16'h0020, dd, 1);

    dd[0] = 16'hABCD;
    wr(16'h1000, dd, 1);
    dd[0] = 16'h1111; dd[1] = 16'h2222; dd[2] = 16'h3333;
    wr(16'hFFFE, dd, 3);
    rd(16'h0042, 0);
    rd(16'h0077, 1);
    dd[0] = 16'hABCD;
    for (int i = 0; i < 4; i++) begin
      wr(16'h1000, dd, 1);
      clk_stop();
    end

    for (int it = 0; it < 60; it++) begin
      logic [15:0] a;
      int t;
      int n;
      t = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0)
        a = 16'hFFFC + 16'($urandom_range(0, 3));
      else
        a = 16'($urandom);
      n = $urandom_range(1, 4);
      for (int j = 0; j < 4; j++) dd[j] = 16'($urandom);
      unique case (t)
        0, 1: wr(a, dd, n);
        2: rd(a, 0);
        3: rd(a, 1);
        default: begin
          rd(a, 2);
          wr(16'($urandom), dd, n);
        end
      endcase
      if ($urandom_range(0, 4) == 0) clk_stop();
    end

    repeat (6) @(posedge gpmc_clk);
    #1;
    chk("wrq_empty", 32'(wrq.size()), 0);
    chk("rdaq_empty", 32'(rdaq.size()), 0);
    chk("rddq_empty", 32'(rddq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
